// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU operand-select codes and the destination scoreboard entry.
package pipe_pkg;

  localparam int unsigned REG_AW     = 3;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned PIPE_DEPTH = 3;

  // Scoreboard slot indices, youngest first
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  localparam logic [SEL_W-1:0] SRC1_WB    = 2'b00;
  localparam logic [SEL_W-1:0] SRC1_MEM   = 2'b01;
  localparam logic [SEL_W-1:0] SRC1_RF    = 2'b10;

  localparam logic [SEL_W-1:0] SRC2_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SRC2_WB    = 2'b01;
  localparam logic [SEL_W-1:0] SRC2_MEM   = 2'b10;
  localparam logic [SEL_W-1:0] SRC2_SHAMT = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against the MEM and WB forwarding candidates; MEM wins.
module fwd_match
  import pipe_pkg::*;
#(
  parameter logic [SEL_W-1:0] SEL_MEM = SRC1_MEM,
  parameter logic [SEL_W-1:0] SEL_WB  = SRC1_WB,
  parameter logic [SEL_W-1:0] SEL_RF  = SRC1_RF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [SEL_W-1:0]  sel_c
);

  always_comb begin
    sel_c = SEL_RF;
    if (use_rs && wb_wr && (wb_rd == rs))   sel_c = SEL_WB;
    if (use_rs && mem_wr && (mem_rd == rs)) sel_c = SEL_MEM;
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// EX/MEM/WB destination scoreboard producing registered ALU operand selects and load-use stalls.
module operand_forward_ctrl
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_use_shamt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall,
  output logic              ex_bubble,
  output logic [SEL_W-1:0]  alu_src1_select,
  output logic [SEL_W-1:0]  alu_src2_select
);

  sb_entry_t        sb_q [PIPE_DEPTH];
  sb_entry_t        sb_d [PIPE_DEPTH];
  logic [SEL_W-1:0] src1_sel_q, src1_sel_d;
  logic [SEL_W-1:0] src2_sel_q, src2_sel_d;
  logic             ex_bubble_q, ex_bubble_d;

  logic             ex_wr, mem_wr;
  logic             load_hit;
  logic             issue;
  logic [SEL_W-1:0] fwd1_sel, fwd2_sel;
  sb_entry_t        id_entry;

  // At the EX-entry edge the current EX entry becomes MEM and the current MEM entry becomes WB
  assign ex_wr  = sb_q[STG_EX].valid  & sb_q[STG_EX].reg_write;
  assign mem_wr = sb_q[STG_MEM].valid & sb_q[STG_MEM].reg_write;

  fwd_match #(.SEL_MEM(SRC1_MEM), .SEL_WB(SRC1_WB), .SEL_RF(SRC1_RF)) u_fwd_src1 (
    .rs     (id_rs1),
    .use_rs (id_use_rs1),
    .mem_wr (ex_wr),
    .mem_rd (sb_q[STG_EX].rd),
    .wb_wr  (mem_wr),
    .wb_rd  (sb_q[STG_MEM].rd),
    .sel_c  (fwd1_sel)
  );

  fwd_match #(.SEL_MEM(SRC2_MEM), .SEL_WB(SRC2_WB), .SEL_RF(SRC2_RF)) u_fwd_src2 (
    .rs     (id_rs2),
    .use_rs (id_use_rs2),
    .mem_wr (ex_wr),
    .mem_rd (sb_q[STG_EX].rd),
    .wb_wr  (mem_wr),
    .wb_rd  (sb_q[STG_MEM].rd),
    .sel_c  (fwd2_sel)
  );

  // Load data only exists in WB, so a consumer directly behind a load must wait one cycle
  always_comb begin
    load_hit = ex_wr & sb_q[STG_EX].mem_read &
               ((id_use_rs1 & (sb_q[STG_EX].rd == id_rs1)) |
                (id_use_rs2 & (sb_q[STG_EX].rd == id_rs2)));
    stall    = mem_busy | (id_valid & ~flush & load_hit);
    issue    = id_valid & ~flush & ~stall;
    id_entry = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
  end

  always_comb begin
    for (int i = 0; i < int'(PIPE_DEPTH); i++) sb_d[i] = sb_q[i];
    src1_sel_d  = src1_sel_q;
    src2_sel_d  = src2_sel_q;
    ex_bubble_d = ex_bubble_q;
    if (!mem_busy) begin
      for (int i = int'(PIPE_DEPTH) - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
      sb_d[STG_EX] = issue ? id_entry : SB_EMPTY;
      src1_sel_d   = issue ? fwd1_sel : SRC1_RF;
      src2_sel_d   = !issue ? SRC2_RF : (id_use_shamt ? SRC2_SHAMT : fwd2_sel);
      ex_bubble_d  = ~issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) sb_q[i] <= SB_EMPTY;
      src1_sel_q  <= SRC1_RF;
      src2_sel_q  <= SRC2_RF;
      ex_bubble_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(PIPE_DEPTH); i++) sb_q[i] <= sb_d[i];
      src1_sel_q  <= src1_sel_d;
      src2_sel_q  <= src2_sel_d;
      ex_bubble_q <= ex_bubble_d;
    end
  end

  assign ex_bubble       = ex_bubble_q;
  assign alu_src1_select = src1_sel_q;
  assign alu_src2_select = src2_sel_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: directed hazard sequences then random traffic vs. an in-flight history model.
module tb_operand_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_use_shamt;
  logic       id_reg_write, id_mem_read, flush, mem_busy;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_bubble;
  logic [1:0] alu_src1_select, alu_src2_select;

  operand_forward_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_use_shamt(id_use_shamt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_busy(mem_busy), .stall(stall), .ex_bubble(ex_bubble),
    .alu_src1_select(alu_src1_select), .alu_src2_select(alu_src2_select)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, valid, flush, busy, u1, u2, sh, wr, ld;
    bit [2:0] rs1, rs2, rd;
  } stim_t;

  // One record per issued slot; a bubble is a record with v=0
  typedef struct {
    bit       v, wr, ld;
    bit [2:0] rd;
  } slot_t;

  slot_t    hist[$];        // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
  bit [1:0] exp_s1, exp_s2;
  bit       exp_bub, exp_stall;
  int       n_vec = 0;
  int       n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // How many slots back the youngest in-flight writer of rs sits (0 = EX, 1 = MEM), 9 if none in reach
  function automatic int producer_age(input bit [2:0] rs);
    for (int a = 0; a < 2; a++)
      if (hist[a].v && hist[a].wr && hist[a].rd == rs) return a;
    return 9;
  endfunction

  function automatic bit model_stall(input stim_t s);
    bit hit;
    hit = hist[0].v && hist[0].wr && hist[0].ld &&
          ((s.u1 && hist[0].rd == s.rs1) || (s.u2 && hist[0].rd == s.rs2));
    return s.busy || (s.valid && !s.flush && hit);
  endfunction

  task automatic model_edge(input stim_t s);
    slot_t n;
    bit    enter;
    int    a1, a2;
    if (s.rst) begin
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back('{v: 0, wr: 0, ld: 0, rd: 0});
      exp_s1 = 2'b10; exp_s2 = 2'b00; exp_bub = 1'b1;
      return;
    end
    if (s.busy) return;
    enter = s.valid && !s.flush && !model_stall(s);
    a1 = s.u1 ? producer_age(s.rs1) : 9;
    a2 = s.u2 ? producer_age(s.rs2) : 9;
    exp_bub = !enter;
    if (!enter) begin
      exp_s1 = 2'b10; exp_s2 = 2'b00;
      n = '{v: 0, wr: 0, ld: 0, rd: 0};
    end else begin
      exp_s1 = (a1 == 0) ? 2'b01 : (a1 == 1) ? 2'b00 : 2'b10;
      exp_s2 = s.sh ? 2'b11 : (a2 == 0) ? 2'b10 : (a2 == 1) ? 2'b01 : 2'b00;
      n = '{v: 1, wr: s.wr, ld: s.ld, rd: s.rd};
    end
    hist.push_front(n);
    void'(hist.pop_back());
  endtask

  task automatic drive(input stim_t s);
    rst = s.rst; id_valid = s.valid; flush = s.flush; mem_busy = s.busy;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_use_shamt = s.sh;
    id_reg_write = s.wr; id_mem_read = s.ld;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
  endtask

  // One clock: drive, check the combinational stall, clock, check the registered EX view
  task automatic step(input stim_t s, input string tag);
    drive(s);
    #1;
    exp_stall = model_stall(s);
    check_eq({tag, ".stall"}, 8'(stall), 8'(exp_stall));
    model_edge(s);
    @(posedge clk);
    #1;
    check_eq({tag, ".bub"}, 8'(ex_bubble), 8'(exp_bub));
    check_eq({tag, ".src1"}, 8'(alu_src1_select), 8'(exp_s1));
    check_eq({tag, ".src2"}, 8'(alu_src2_select), 8'(exp_s2));
    @(negedge clk);
  endtask

  // Issue an instruction, replaying it while the front end is held (bounded)
  task automatic issue(input stim_t s, input string tag);
    stim_t r;
    step(s, tag);
    r = s; r.busy = 0; r.flush = 0; r.rst = 0;
    for (int k = 0; k < 4 && exp_stall; k++) step(r, {tag, ".replay"});
    if (exp_stall) check_eq({tag, ".stall_bound"}, 8'(stall), 8'(0));
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t alu(input bit [2:0] rd, input bit [2:0] rs1, input bit [2:0] rs2);
    stim_t s;
    s = nop();
    s.valid = 1; s.u1 = 1; s.u2 = 1; s.wr = 1;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    return s;
  endfunction

  function automatic stim_t ldd(input bit [2:0] rd, input bit [2:0] base);
    stim_t s;
    s = alu(rd, base, 3'd0);
    s.u2 = 0; s.ld = 1;
    return s;
  endfunction

  function automatic stim_t shl(input bit [2:0] rd);
    stim_t s;
    s = alu(rd, rd, 3'd5);
    s.u2 = 0; s.sh = 1;
    return s;
  endfunction

  function automatic stim_t rnd_instr();
    stim_t s;
    s = nop();
    s.valid = ($urandom_range(9) != 0);
    s.u1 = $urandom_range(1); s.u2 = $urandom_range(1); s.sh = ($urandom_range(4) == 0);
    s.ld = ($urandom_range(3) == 0);
    s.wr = s.ld ? 1'b1 : ($urandom_range(5) != 0);
    s.rs1 = 3'($urandom_range(3)); s.rs2 = 3'($urandom_range(3)); s.rd = 3'($urandom_range(3));
    if ($urandom_range(7) == 0) s.rd = 3'($urandom_range(7));
    return s;
  endfunction

  initial begin
    stim_t s, r;
    s = nop(); s.rst = 1;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('{v: 0, wr: 0, ld: 0, rd: 0});
    drive(s);
    @(negedge clk);
    step(s, "reset");
    step(s, "reset2");

    // Back-to-back RAW: MEM forward on src1
    issue(alu(3'd1, 3'd2, 3'd3), "t1.prod");
    issue(alu(3'd2, 3'd1, 3'd3), "t1.cons");
    check_eq("t1.src1_mem", 8'(alu_src1_select), 8'h01);

    // One instruction apart: WB forward on src2
    issue(alu(3'd1, 3'd2, 3'd3), "t2.prod");
    issue(nop(), "t2.nop");
    issue(alu(3'd4, 3'd5, 3'd1), "t2.cons");
    check_eq("t2.src2_wb", 8'(alu_src2_select), 8'h01);

    // Two producers of R1: the younger (MEM) wins
    issue(alu(3'd1, 3'd2, 3'd3), "t3.add");
    issue(alu(3'd1, 3'd4, 3'd5), "t3.or");
    issue(alu(3'd2, 3'd1, 3'd1), "t3.and");

    // Load-use: one stall cycle, then WB forward
    issue(ldd(3'd3, 3'd6), "t4.ldd");
    issue(alu(3'd4, 3'd3, 3'd0), "t4.use");
    check_eq("t4.src1_wb", 8'(alu_src1_select), 8'h00);

    // Load-use with flush the same cycle, then mem_busy freeze mid-sequence
    issue(ldd(3'd3, 3'd6), "t5.ldd");
    s = alu(3'd4, 3'd3, 3'd3); s.flush = 1;
    step(s, "t5.flush");
    issue(ldd(3'd2, 3'd6), "t5.ld2");
    s = alu(3'd5, 3'd2, 3'd1); s.busy = 1;
    for (int i = 0; i < 3; i++) step(s, "t5.busy");
    s.busy = 0;
    issue(s, "t5.resume");

    // Shift with R2 in MEM, then reset while stalled
    issue(alu(3'd2, 3'd1, 3'd1), "t6.prod");
    issue(shl(3'd2), "t6.shl");
    issue(ldd(3'd7, 3'd0), "t6.ldd");
    s = alu(3'd1, 3'd7, 3'd7); s.rst = 1;
    step(s, "t6.rst");
    s.rst = 0;
    step(s, "t6.after");

    // Random traffic; a stalled decode slot keeps its instruction
    r = rnd_instr();
    for (int c = 0; c < 3000; c++) begin
      if (!exp_stall || r.flush || r.rst) r = rnd_instr();
      r.rst   = ($urandom_range(99) == 0);
      r.busy  = ($urandom_range(9) == 0);
      r.flush = ($urandom_range(11) == 0);
      step(r, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
